// File: rtl/alu_rsv_station_param.sv
// rtl/alu_rsv_station_param.sv - ALU reservation station with multi-port CDB wakeup and oldest-first issue
module alu_rsv_station_param #(
   parameter int DEPTH    = 16,
   parameter int ROB_ID_W = 4,
   parameter int DATA_W   = 32,
   parameter int OP_W     = 6,
   parameter int NUM_CDB  = 2
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         rdy,
   input  logic                         flush,
   input  logic                         in_valid,
   output logic                         in_ready,
   input  logic [DATA_W-1:0]            in_pc,
   input  logic [OP_W-1:0]              in_op,
   input  logic [DATA_W-1:0]            in_imm,
   input  logic [ROB_ID_W-1:0]          in_rob_id,
   input  logic                         in_rs1_rdy,
   input  logic                         in_rs2_rdy,
   input  logic [DATA_W-1:0]            in_rs1_val,
   input  logic [DATA_W-1:0]            in_rs2_val,
   input  logic [ROB_ID_W-1:0]          in_rs1_tag,
   input  logic [ROB_ID_W-1:0]          in_rs2_tag,
   input  logic [NUM_CDB-1:0]           cdb_valid,
   input  logic [NUM_CDB*ROB_ID_W-1:0]  cdb_tag,
   input  logic [NUM_CDB*DATA_W-1:0]    cdb_value,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic [OP_W-1:0]              out_op,
   output logic [DATA_W-1:0]            out_pc,
   output logic [DATA_W-1:0]            out_rs1,
   output logic [DATA_W-1:0]            out_rs2,
   output logic [DATA_W-1:0]            out_imm,
   output logic [ROB_ID_W-1:0]          out_rob_id,
   output logic [$clog2(DEPTH):0]       occupancy
);
   localparam int IDX_W = $clog2(DEPTH);
   localparam int OCC_W = IDX_W + 1;

   // Entry storage
   logic [DEPTH-1:0]    ent_valid;
   logic [DEPTH-1:0]    rs1_ok;
   logic [DEPTH-1:0]    rs2_ok;
   logic [OP_W-1:0]     e_op  [DEPTH];
   logic [DATA_W-1:0]   e_pc  [DEPTH];
   logic [DATA_W-1:0]   e_imm [DEPTH];
   logic [ROB_ID_W-1:0] e_rob [DEPTH];
   logic [DATA_W-1:0]   e_rs1 [DEPTH];
   logic [DATA_W-1:0]   e_rs2 [DEPTH];
   logic [ROB_ID_W-1:0] e_t1  [DEPTH];
   logic [ROB_ID_W-1:0] e_t2  [DEPTH];
   // older[i][j] set means entry i was dispatched before entry j
   logic [DEPTH-1:0]    older [DEPTH];

   logic [DEPTH-1:0]    ent_ready;
   logic [DEPTH-1:0]    is_oldest;
   logic [IDX_W-1:0]    free_idx;
   logic [IDX_W-1:0]    sel_idx;
   logic                any_ready;
   logic                load_en;
   logic                dispatch;
   logic                issue;

   logic [DEPTH-1:0]    wake1;
   logic [DEPTH-1:0]    wake2;
   logic [DATA_W-1:0]   wake1_val [DEPTH];
   logic [DATA_W-1:0]   wake2_val [DEPTH];
   logic                byp1;
   logic                byp2;
   logic [DATA_W-1:0]   byp1_val;
   logic [DATA_W-1:0]   byp2_val;

   // Readiness and handshakes come from registered state only, so in_ready never depends on out_ready
   assign ent_ready = ent_valid & rs1_ok & rs2_ok;
   assign any_ready = |ent_ready;
   assign in_ready  = rdy & (occupancy < OCC_W'(DEPTH));
   assign load_en   = ~out_valid | out_ready;
   assign dispatch  = in_valid & in_ready;
   assign issue     = rdy & load_en & any_ready;

   // Lowest-index free slot for the next dispatch
   always_comb begin
      free_idx = '0;
      for (int i = DEPTH - 1; i >= 0; i--) begin
         if (!ent_valid[i]) free_idx = IDX_W'(i);
      end
   end

   // Oldest ready entry: ready and no other ready entry is older than it
   always_comb begin
      is_oldest = ent_ready;
      for (int i = 0; i < DEPTH; i++) begin
         for (int j = 0; j < DEPTH; j++) begin
            if (ent_ready[j] && older[j][i]) is_oldest[i] = 1'b0;
         end
      end
      sel_idx = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (is_oldest[i]) sel_idx = IDX_W'(i);
      end
   end

   // CDB tag match per pending operand and for the dispatch bypass; lowest port wins on duplicates
   always_comb begin
      wake1    = '0;
      wake2    = '0;
      byp1     = 1'b0;
      byp2     = 1'b0;
      byp1_val = '0;
      byp2_val = '0;
      for (int i = 0; i < DEPTH; i++) begin
         wake1_val[i] = '0;
         wake2_val[i] = '0;
      end
      for (int k = NUM_CDB - 1; k >= 0; k--) begin
         if (cdb_valid[k]) begin
            for (int i = 0; i < DEPTH; i++) begin
               if (cdb_tag[k*ROB_ID_W +: ROB_ID_W] == e_t1[i]) begin
                  wake1[i]     = 1'b1;
                  wake1_val[i] = cdb_value[k*DATA_W +: DATA_W];
               end
               if (cdb_tag[k*ROB_ID_W +: ROB_ID_W] == e_t2[i]) begin
                  wake2[i]     = 1'b1;
                  wake2_val[i] = cdb_value[k*DATA_W +: DATA_W];
               end
            end
            if (cdb_tag[k*ROB_ID_W +: ROB_ID_W] == in_rs1_tag) begin
               byp1     = 1'b1;
               byp1_val = cdb_value[k*DATA_W +: DATA_W];
            end
            if (cdb_tag[k*ROB_ID_W +: ROB_ID_W] == in_rs2_tag) begin
               byp2     = 1'b1;
               byp2_val = cdb_value[k*DATA_W +: DATA_W];
            end
         end
      end
   end

   // Entry, age matrix, output register and occupancy update
   always_ff @(posedge clk) begin
      if (rst || flush) begin
         ent_valid  <= '0;
         rs1_ok     <= '0;
         rs2_ok     <= '0;
         for (int i = 0; i < DEPTH; i++) older[i] <= '0;
         occupancy  <= '0;
         out_valid  <= 1'b0;
         out_op     <= '0;
         out_pc     <= '0;
         out_rs1    <= '0;
         out_rs2    <= '0;
         out_imm    <= '0;
         out_rob_id <= '0;
      end else if (rdy) begin
         for (int i = 0; i < DEPTH; i++) begin
            if (ent_valid[i] && !rs1_ok[i] && wake1[i]) begin
               rs1_ok[i] <= 1'b1;
               e_rs1[i]  <= wake1_val[i];
            end
            if (ent_valid[i] && !rs2_ok[i] && wake2[i]) begin
               rs2_ok[i] <= 1'b1;
               e_rs2[i]  <= wake2_val[i];
            end
         end
         if (load_en) begin
            out_valid <= any_ready;
            if (any_ready) begin
               out_op             <= e_op[sel_idx];
               out_pc             <= e_pc[sel_idx];
               out_rs1            <= e_rs1[sel_idx];
               out_rs2            <= e_rs2[sel_idx];
               out_imm            <= e_imm[sel_idx];
               out_rob_id         <= e_rob[sel_idx];
               ent_valid[sel_idx] <= 1'b0;
            end
         end
         if (dispatch) begin
            ent_valid[free_idx] <= 1'b1;
            e_op[free_idx]      <= in_op;
            e_pc[free_idx]      <= in_pc;
            e_imm[free_idx]     <= in_imm;
            e_rob[free_idx]     <= in_rob_id;
            e_t1[free_idx]      <= in_rs1_tag;
            e_t2[free_idx]      <= in_rs2_tag;
            rs1_ok[free_idx]    <= in_rs1_rdy | byp1;
            rs2_ok[free_idx]    <= in_rs2_rdy | byp2;
            e_rs1[free_idx]     <= in_rs1_rdy ? in_rs1_val : byp1_val;
            e_rs2[free_idx]     <= in_rs2_rdy ? in_rs2_val : byp2_val;
            // New entry is younger than everything currently held
            older[free_idx]     <= '0;
            for (int j = 0; j < DEPTH; j++) begin
               if (IDX_W'(j) != free_idx) older[j][free_idx] <= ent_valid[j];
            end
         end
         occupancy <= occupancy + OCC_W'(dispatch) - OCC_W'(issue);
      end
   end

endmodule

// File: tb/tb_alu_rsv_station_param.sv
// tb/tb_alu_rsv_station_param.sv - scoreboard bench for alu_rsv_station_param
module tb_alu_rsv_station_param;
   localparam int DEPTH    = 16;
   localparam int ROB_ID_W = 4;
   localparam int DATA_W   = 32;
   localparam int OP_W     = 6;
   localparam int NUM_CDB  = 2;

   logic                        clk = 1'b0;
   logic                        rst, rdy, flush, in_valid, in_ready;
   logic [DATA_W-1:0]           in_pc, in_imm, in_rs1_val, in_rs2_val;
   logic [OP_W-1:0]             in_op;
   logic [ROB_ID_W-1:0]         in_rob_id, in_rs1_tag, in_rs2_tag;
   logic                        in_rs1_rdy, in_rs2_rdy;
   logic [NUM_CDB-1:0]          cdb_valid;
   logic [NUM_CDB*ROB_ID_W-1:0] cdb_tag;
   logic [NUM_CDB*DATA_W-1:0]   cdb_value;
   logic                        out_valid, out_ready;
   logic [OP_W-1:0]             out_op;
   logic [DATA_W-1:0]           out_pc, out_rs1, out_rs2, out_imm;
   logic [ROB_ID_W-1:0]         out_rob_id;
   logic [$clog2(DEPTH):0]      occupancy;

   alu_rsv_station_param #(.DEPTH(DEPTH), .ROB_ID_W(ROB_ID_W), .DATA_W(DATA_W),
                           .OP_W(OP_W), .NUM_CDB(NUM_CDB)) dut (
      .clk(clk), .rst(rst), .rdy(rdy), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_op(in_op),
      .in_imm(in_imm), .in_rob_id(in_rob_id),
      .in_rs1_rdy(in_rs1_rdy), .in_rs2_rdy(in_rs2_rdy),
      .in_rs1_val(in_rs1_val), .in_rs2_val(in_rs2_val),
      .in_rs1_tag(in_rs1_tag), .in_rs2_tag(in_rs2_tag),
      .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_value(cdb_value),
      .out_valid(out_valid), .out_ready(out_ready), .out_op(out_op), .out_pc(out_pc),
      .out_rs1(out_rs1), .out_rs2(out_rs2), .out_imm(out_imm), .out_rob_id(out_rob_id),
      .occupancy(occupancy)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [OP_W-1:0]     op;
      logic [DATA_W-1:0]   pc, imm, v1, v2;
      logic [ROB_ID_W-1:0] rob, t1, t2;
      bit                  ok1, ok2;
   } ent_t;

   // Reference: station contents in dispatch order (oldest first) plus the pending output
   ent_t mq[$];
   ent_t eq[$];
   bit   m_ov = 1'b0;
   bit   mon_en = 1'b0;
   int   checks = 0;
   int   failures = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
      end
   endtask

   function automatic bit cdb_find(input logic [ROB_ID_W-1:0] tag, output logic [DATA_W-1:0] val);
      val = '0;
      for (int k = 0; k < NUM_CDB; k++) begin
         if (cdb_valid[k] && cdb_tag[k*ROB_ID_W +: ROB_ID_W] == tag) begin
            val = cdb_value[k*DATA_W +: DATA_W];
            return 1'b1;
         end
      end
      return 1'b0;
   endfunction

   // Reference model advances on each clock edge from the bench-driven inputs
   always @(posedge clk) begin
      bit acc;
      int pick;
      ent_t e;
      logic [DATA_W-1:0] v;
      if (rst || flush) begin
         mq.delete();
         eq.delete();
         m_ov = 1'b0;
      end else if (rdy) begin
         acc = in_valid && (mq.size() < DEPTH);
         if (!m_ov || out_ready) begin
            pick = -1;
            for (int k = 0; k < mq.size(); k++)
               if (pick < 0 && mq[k].ok1 && mq[k].ok2) pick = k;
            if (pick >= 0) begin
               eq.push_back(mq[pick]);
               mq.delete(pick);
               m_ov = 1'b1;
            end else begin
               m_ov = 1'b0;
            end
         end
         for (int k = 0; k < mq.size(); k++) begin
            e = mq[k];
            if (!e.ok1 && cdb_find(e.t1, v)) begin e.ok1 = 1'b1; e.v1 = v; end
            if (!e.ok2 && cdb_find(e.t2, v)) begin e.ok2 = 1'b1; e.v2 = v; end
            mq[k] = e;
         end
         if (acc) begin
            e.op = in_op; e.pc = in_pc; e.imm = in_imm; e.rob = in_rob_id;
            e.t1 = in_rs1_tag; e.t2 = in_rs2_tag;
            e.ok1 = in_rs1_rdy; e.v1 = in_rs1_val;
            e.ok2 = in_rs2_rdy; e.v2 = in_rs2_val;
            if (!e.ok1 && cdb_find(e.t1, v)) begin e.ok1 = 1'b1; e.v1 = v; end
            if (!e.ok2 && cdb_find(e.t2, v)) begin e.ok2 = 1'b1; e.v2 = v; end
            mq.push_back(e);
         end
      end
   end

   // Monitor: compares DUT outputs mid-cycle and retires the expected issue on handshake
   always @(negedge clk) begin
      if (mon_en) begin
         chk("occupancy", 32'(occupancy), 32'(mq.size()));
         chk("in_ready", 32'(in_ready), 32'(rdy && (mq.size() < DEPTH)));
         chk("out_valid", 32'(out_valid), 32'(m_ov));
         if (out_valid) begin
            if (eq.size() == 0) begin
               chk("unexpected_issue", 32'(out_valid), 32'(0));
            end else begin
               chk("out_op", 32'(out_op), 32'(eq[0].op));
               chk("out_pc", out_pc, eq[0].pc);
               chk("out_rs1", out_rs1, eq[0].v1);
               chk("out_rs2", out_rs2, eq[0].v2);
               chk("out_imm", out_imm, eq[0].imm);
               chk("out_rob_id", 32'(out_rob_id), 32'(eq[0].rob));
               if (out_ready && rdy && !flush && !rst) void'(eq.pop_front());
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      in_valid = 1'b0; cdb_valid = '0; flush = 1'b0; rdy = 1'b1;
   endtask

   task automatic disp(input logic [OP_W-1:0] op, input logic [ROB_ID_W-1:0] rob,
                       input bit r1, input logic [DATA_W-1:0] v1, input logic [ROB_ID_W-1:0] t1,
                       input bit r2, input logic [DATA_W-1:0] v2, input logic [ROB_ID_W-1:0] t2);
      in_valid = 1'b1; in_op = op; in_rob_id = rob;
      in_pc = 32'h1000 + 32'(rob) * 4; in_imm = 32'h100 + 32'(op);
      in_rs1_rdy = r1; in_rs1_val = v1; in_rs1_tag = t1;
      in_rs2_rdy = r2; in_rs2_val = v2; in_rs2_tag = t2;
   endtask

   task automatic bcast(input int port, input logic [ROB_ID_W-1:0] tag, input logic [DATA_W-1:0] val);
      cdb_valid[port] = 1'b1;
      cdb_tag[port*ROB_ID_W +: ROB_ID_W] = tag;
      cdb_value[port*DATA_W +: DATA_W] = val;
   endtask

   initial begin
      int pv;
      rst = 1'b1; idle(); out_ready = 1'b1;
      in_pc = '0; in_op = '0; in_imm = '0; in_rob_id = '0;
      in_rs1_rdy = 1'b0; in_rs2_rdy = 1'b0; in_rs1_val = '0; in_rs2_val = '0;
      in_rs1_tag = '0; in_rs2_tag = '0; cdb_tag = '0; cdb_value = '0;
      tick();
      mon_en = 1'b1;
      tick();
      chk("reset_occupancy", 32'(occupancy), 32'(0));
      chk("reset_out_valid", 32'(out_valid), 32'(0));
      rst = 1'b0;
      tick();

      // Basic issue
      disp(6'd3, 4'd1, 1, 32'd10, 4'd0, 1, 32'd20, 4'd0); tick(); idle();
      repeat (4) tick();

      // Insert bypass on port 1, later wakeup on port 0
      disp(6'd4, 4'd2, 0, 32'd0, 4'd5, 1, 32'd1, 4'd0); tick();
      disp(6'd5, 4'd3, 0, 32'd0, 4'd6, 1, 32'd2, 4'd0); bcast(1, 4'd6, 32'hBEEF); tick(); idle();
      repeat (3) tick();
      bcast(0, 4'd5, 32'h5555); tick(); idle();
      repeat (3) tick();

      // Oldest-first across slot reuse
      disp(6'd7, 4'd4, 0, 32'd0, 4'd7, 1, 32'd3, 4'd0); tick();
      disp(6'd8, 4'd5, 1, 32'd11, 4'd0, 1, 32'd12, 4'd0); tick();
      disp(6'd9, 4'd6, 1, 32'd13, 4'd0, 1, 32'd14, 4'd0); tick(); idle();
      out_ready = 1'b0; bcast(0, 4'd7, 32'h77); tick(); idle();
      out_ready = 1'b1;
      disp(6'd10, 4'd7, 1, 32'd15, 4'd0, 1, 32'd16, 4'd0); tick(); idle();
      repeat (6) tick();

      // Backpressure with three ready entries
      out_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         disp(6'(11 + i), 4'(8 + i), 1, 32'(100 + i), 4'd0, 1, 32'(200 + i), 4'd0); tick();
      end
      idle(); repeat (4) tick();
      out_ready = 1'b1; repeat (5) tick();

      // Full station, dropped dispatch, single wakeup, stalled broadcast
      for (int i = 0; i < DEPTH; i++) begin
         disp(6'(i), 4'(i), 0, 32'd0, 4'(i), 1, 32'(i), 4'd0); tick();
      end
      disp(6'd63, 4'd15, 1, 32'd1, 4'd0, 1, 32'd1, 4'd0); tick(); idle();
      bcast(0, 4'd3, 32'h3333); tick(); idle();
      repeat (2) tick();
      rdy = 1'b0; bcast(0, 4'd4, 32'h4444); tick(); idle();
      repeat (3) tick();

      // Flush with five entries held
      out_ready = 1'b0;
      flush = 1'b1; tick(); idle();
      for (int i = 0; i < 5; i++) begin
         disp(6'(20 + i), 4'(i), 1, 32'(i), 4'd0, 1, 32'(i), 4'd0); tick();
      end
      idle(); flush = 1'b1; tick(); idle();
      chk("flush_occupancy", 32'(occupancy), 32'(0));
      chk("flush_out_valid", 32'(out_valid), 32'(0));
      chk("flush_in_ready", 32'(in_ready), 32'(1));
      out_ready = 1'b1; repeat (3) tick();

      // Randomized traffic
      for (int blk = 0; blk < 6; blk++) begin
         pv = 20 + blk * 15;
         for (int c = 0; c < 500; c++) begin
            in_valid   = ($urandom % 100) < pv;
            in_op      = OP_W'($urandom);
            in_pc      = $urandom;
            in_imm     = $urandom;
            in_rob_id  = ROB_ID_W'($urandom);
            in_rs1_rdy = ($urandom % 3) != 0;
            in_rs2_rdy = ($urandom % 3) != 0;
            in_rs1_val = $urandom;
            in_rs2_val = $urandom;
            in_rs1_tag = ROB_ID_W'($urandom);
            in_rs2_tag = ROB_ID_W'($urandom);
            cdb_valid  = NUM_CDB'($urandom);
            cdb_tag    = (NUM_CDB*ROB_ID_W)'($urandom);
            cdb_value  = {$urandom, $urandom};
            out_ready  = ($urandom % 100) < 70;
            rdy        = ($urandom % 100) < 90;
            flush      = ($urandom % 250) == 0;
            tick();
         end
      end

      idle(); out_ready = 1'b1;
      repeat (4) tick();
      flush = 1'b1; tick(); idle();
      chk("final_occupancy", 32'(occupancy), 32'(0));
      chk("final_out_valid", 32'(out_valid), 32'(0));
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/alu_rsv_station_param.md
Name: alu_rsv_station_param

Overview:
Parametrised ALU reservation station with multi-port wakeup. It sits between the decoder/register-file dispatch stage and the ALU, and holds DEPTH in-flight ALU ops until both source operands are available. Wakeup comes from NUM_CDB result broadcast buses. Among ready entries, the oldest issues first, and the ALU side is a valid/ready-stalled output register.

Parameters:
DEPTH, 16, number of entries (power of two, >=2)
ROB_ID_W, 4, ROB tag width
DATA_W, 32, operand/immediate/pc width
OP_W, 6, op id width
NUM_CDB, 2, number of result broadcast ports (>=1)

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
rdy  in  1  global enable; low = hold all state
flush  in  1  mispredict roll-back; clear all entries
in_valid  in  1  dispatch request
in_ready  out  1  free entry available
in_pc  in  DATA_W  instruction pc
in_op  in  OP_W  op id
in_imm  in  DATA_W  immediate
in_rob_id  in  ROB_ID_W  destination ROB tag
in_rs1_rdy / in_rs2_rdy  in  1 each  operand value already valid
in_rs1_val / in_rs2_val  in  DATA_W each  operand value
in_rs1_tag / in_rs2_tag  in  ROB_ID_W each  producer tag when not ready
cdb_valid  in  NUM_CDB  per-port broadcast valid
cdb_tag  in  NUM_CDB*ROB_ID_W  packed tags, port 0 in LSBs
cdb_value  in  NUM_CDB*DATA_W  packed values, port 0 in LSBs
out_valid  out  1  issue to ALU
out_ready  in  1  ALU accepts
out_op  out  OP_W  op id
out_pc  out  DATA_W  pc
out_rs1 / out_rs2  out  DATA_W each  operand values
out_imm  out  DATA_W  immediate
out_rob_id  out  ROB_ID_W  ROB tag
occupancy  out  clog2(DEPTH)+1  valid entry count

Behaviour:
- rst or flush (flush equal priority to rst, above rdy): all entries invalid, age state cleared, occupancy=0, out_valid=0. Other out_* reset to 0. flush also drops a pending out_valid.
- rdy=0: no state changes; in_ready=0; CDB inputs ignored. The whole core stalls together, so no broadcast is lost.
- in_ready = rdy & (occupancy < DEPTH). It is computed from registered state only and does not count same-cycle issue (no combinational loop with out_ready).
- Dispatch (in_valid & in_ready): write lowest-index free entry; record age so the entry is younger than all existing entries.
- Dispatch operand capture:
  - in_rsN_rdy=1: store in_rsN_val, mark valid.
  - in_rsN_rdy=0 and some cdb_valid[k] with cdb_tag[k]==in_rsN_tag in the same cycle: store cdb_value[k], mark valid (insert bypass).
  - Otherwise: store tag, mark pending.
- Wakeup: for each pending operand of each valid entry, a CDB match captures the value and marks valid at the next edge. If multiple ports match the same tag, the lowest port index wins (not expected; ROB tags are unique).
- Entry ready = valid & rs1 valid & rs2 valid, evaluated on registered state only. An entry dispatched or woken in cycle t is issue-eligible from cycle t+1. Minimum dispatch-to-out_valid latency is 2 cycles for an entry with both operands ready.
- Output register: load enabled when out_valid==0 or out_ready==1.
  - If enabled and any entry is ready: select the oldest ready entry (age matrix; ties impossible), copy its fields to out_*, set out_valid=1, free the entry that edge.
  - If enabled and no entry is ready: out_valid<=0.
  - While out_valid & ~out_ready: out_* held stable, no issue.
- Simultaneous dispatch + issue in the same cycle: both take effect. occupancy +0 net. The freed slot is reusable from the next cycle.
- Full (occupancy==DEPTH): in_ready=0; wakeup and issue continue. Issue frees a slot, and in_ready rises the following cycle.
- occupancy updates every edge: +dispatch −issue. It never exceeds DEPTH or underflows.
- Age ordering survives slot reuse. Older entries always win over newer ones regardless of slot index.

Test Plan:
- Reset/flush: fill 5 entries, assert flush -> next cycle occupancy=0, out_valid=0, in_ready=1; no issue follows.
- Basic issue: dispatch op=3, rs1=10, rs2=20 (both rdy), out_ready=1 -> out_valid=1 two cycles after dispatch with out_rs1=10, out_rs2=20, correct rob_id; occupancy returns to 0.
- Wakeup/bypass: entry A waits on tag 5, entry B waits on tag 6. CDB port1 sends tag 6, value 0xBEEF, in the same cycle B is dispatched -> B captures 0xBEEF via bypass and issues first. A issues after cdb0 sends tag 5.
- Oldest-first: dispatch A (slot0, pending), then B and C (ready). Free slot0 by issuing A, then dispatch D (ready) into slot0 -> issue order B, C, D.
- Backpressure: out_ready=0 for 4 cycles with 3 ready entries -> out_* stable and identical across cycles; occupancy=2 (one held in output). Release -> one issue per cycle.
- Full: DEPTH=16 pending entries -> in_ready=0, and an in_valid pulse is dropped. Broadcast one tag -> issue, and in_ready=1 the next cycle. rdy=0 during a broadcast -> nothing captured.
